// File: rtl/key_entry_buffer.sv
// key_entry_buffer: debounces the keypad scanner's key vector, accepts one key
// per press/release cycle and maintains an 8-digit entry buffer for the display.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       1 = key actions applied, 0 = actions suppressed (press tracking continues)
//   key[15:0]    raw key levels, bit i high = key i pressed (asynchronous)
//   digits[31:0] display word, nibble 0 is the rightmost digit
//   digit_count  number of entered digits, 0..8
//   entry_value  copy of digits captured on enter
//   entry_valid  one-cycle pulse when entry_value updates
//   overflow     one-cycle pulse when a digit is rejected on a full buffer
module key_entry_buffer #(
  parameter int unsigned DEB_CYCLES = 100000,
  parameter int unsigned CNT_W      = 17,
  parameter logic [3:0]  BLANK      = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] key,
  output logic [31:0] digits,
  output logic [3:0]  digit_count,
  output logic [31:0] entry_value,
  output logic        entry_valid,
  output logic        overflow
);

  localparam int unsigned KEY_W     = 16;
  localparam int unsigned MAX_DIG   = 8;
  localparam int unsigned KEY_BKSP  = 10;
  localparam int unsigned KEY_CLEAR = 11;
  localparam int unsigned KEY_ENTER = 12;

  localparam logic [31:0] ALL_BLANK = {8{BLANK}};

  typedef enum logic {
    IDLE,
    WAIT_RELEASE
  } state_t;

  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_ks;
  logic [KEY_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_stable;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_digits;
  logic [3:0]  r_count;
  logic [31:0] r_entry_value;
  logic        r_entry_valid;
  logic        r_overflow;

  logic [31:0] w_digits_next;
  logic [3:0]  w_count_next;
  logic [31:0] w_entry_value_next;
  logic        w_entry_valid_next;
  logic        w_overflow_next;
  logic        w_onehot;
  logic [3:0]  w_idx;

  // Synchronizer, debounce counter and stable key vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_ks     <= '0;
      r_last   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_sync1 <= key;
      r_ks    <= r_sync1;
      r_last  <= r_ks;
      if (r_ks != r_last) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_W'(DEB_CYCLES)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_ks == r_last) && (r_cnt == CNT_W'(DEB_CYCLES - 1))) begin
        r_stable <= r_ks;
      end
    end
  end

  // Exactly one bit set: x nonzero and x & (x-1) clears its only bit
  assign w_onehot = (r_stable != '0) && ((r_stable & (r_stable - 16'd1)) == '0);

  // Next-state and buffer update decision
  always_comb begin
    w_state_next       = r_state;
    w_digits_next      = r_digits;
    w_count_next       = r_count;
    w_entry_value_next = r_entry_value;
    w_entry_valid_next = 1'b0;
    w_overflow_next    = 1'b0;
    w_idx              = '0;

    for (int i = 0; i < int'(KEY_W); i++) begin
      if (r_stable[i]) w_idx = 4'(i);
    end

    case (r_state)
      IDLE: begin
        if (r_stable != '0) begin
          // Any press (chord or single) arms release tracking; only a
          // single key acts, and only while enabled.
          w_state_next = WAIT_RELEASE;
          if (w_onehot && enable) begin
            if (w_idx <= 4'd9) begin
              if (r_count < 4'(MAX_DIG)) begin
                w_digits_next = {r_digits[27:0], w_idx};
                w_count_next  = r_count + 4'd1;
              end else begin
                w_overflow_next = 1'b1;
              end
            end else if (w_idx == 4'(KEY_BKSP)) begin
              if (r_count != 4'd0) begin
                w_digits_next = {BLANK, r_digits[31:4]};
                w_count_next  = r_count - 4'd1;
              end
            end else if (w_idx == 4'(KEY_CLEAR)) begin
              w_digits_next = ALL_BLANK;
              w_count_next  = 4'd0;
            end else if (w_idx == 4'(KEY_ENTER)) begin
              w_entry_value_next = r_digits;
              w_entry_valid_next = 1'b1;
              w_digits_next      = ALL_BLANK;
              w_count_next       = 4'd0;
            end
          end
        end
      end
      WAIT_RELEASE: begin
        if (r_stable == '0) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_digits      <= ALL_BLANK;
      r_count       <= '0;
      r_entry_value <= '0;
      r_entry_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_digits      <= w_digits_next;
      r_count       <= w_count_next;
      r_entry_value <= w_entry_value_next;
      r_entry_valid <= w_entry_valid_next;
      r_overflow    <= w_overflow_next;
    end
  end

  assign digits      = r_digits;
  assign digit_count = r_count;
  assign entry_value = r_entry_value;
  assign entry_valid = r_entry_valid;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_key_entry_buffer.sv
// tb_key_entry_buffer: directed stimulus with a scoreboard of expected buffer
// states, checked with immediate assertions.
module tb_key_entry_buffer;

  localparam int unsigned DEB   = 4;
  localparam int unsigned CNT_W = 3;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] key;
  logic [31:0] digits;
  logic [3:0]  digit_count;
  logic [31:0] entry_value;
  logic        entry_valid;
  logic        overflow;

  key_entry_buffer #(
    .DEB_CYCLES(DEB),
    .CNT_W     (CNT_W),
    .BLANK     (4'hF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .key        (key),
    .digits     (digits),
    .digit_count(digit_count),
    .entry_value(entry_value),
    .entry_valid(entry_valid),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_digits = 32'hFFFF_FFFF;
  logic [3:0]  m_count  = 4'd0;
  logic [31:0] m_ev     = 32'h0;
  int          m_nv     = 0;
  int          m_no     = 0;

  // Pulse monitor: counts pulses and flags any pulse longer than one cycle
  int n_valid = 0;
  int n_ovf   = 0;
  bit prev_v  = 1'b0;
  bit prev_o  = 1'b0;
  bit dbl     = 1'b0;
  always @(negedge clk) begin
    if (entry_valid) n_valid <= n_valid + 1;
    if (overflow)    n_ovf   <= n_ovf + 1;
    if ((entry_valid && prev_v) || (overflow && prev_o)) dbl <= 1'b1;
    prev_v <= entry_valid;
    prev_o <= overflow;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_key(input int idx);
    if (idx <= 9) begin
      if (m_count < 4'd8) begin
        m_digits = {m_digits[27:0], 4'(idx)};
        m_count  = m_count + 4'd1;
      end else begin
        m_no++;
      end
    end else if (idx == 10) begin
      if (m_count != 4'd0) begin
        m_digits = {4'hF, m_digits[31:4]};
        m_count  = m_count - 4'd1;
      end
    end else if (idx == 11) begin
      m_digits = 32'hFFFF_FFFF;
      m_count  = 4'd0;
    end else if (idx == 12) begin
      m_ev     = m_digits;
      m_nv++;
      m_digits = 32'hFFFF_FFFF;
      m_count  = 4'd0;
    end
  endtask

  task automatic push_exp();
    exp_q.push_back('{d: m_digits, c: m_count});
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_digits"}, digits, e.d);
      check({tag, "_count"}, 32'(digit_count), 32'(e.c));
    end
  endtask

  // Press k for hold cycles, release for 10; act_idx < 0 means no action expected
  task automatic press(input logic [15:0] k, input int act_idx, input int hold);
    key = k;
    if (act_idx >= 0) model_key(act_idx);
    push_exp();
    tick(hold);
    key = 16'h0;
    tick(10);
  endtask

  int lat;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    key    = 16'h0;
    tick(3);
    check("rst_digits", digits, 32'hFFFF_FFFF);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_entry_value", entry_value, 32'h0);
    check("rst_entry_valid", 32'(entry_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Digits 1, 2, 3
    press(16'h0002, 1, 10); sb_check("dig1");
    press(16'h0004, 2, 10); sb_check("dig2");
    press(16'h0008, 3, 10); sb_check("dig3");
    check("dig123_word", digits, 32'hFFFF_F123);

    // Backspace then enter
    press(16'h0400, 10, 10); sb_check("bksp");
    check("bksp_word", digits, 32'hFFFF_FF12);
    press(16'h1000, 12, 10); sb_check("enter");
    check("enter_value", entry_value, m_ev);
    check("enter_value_abs", entry_value, 32'hFFFF_FF12);
    check("enter_pulses", 32'(n_valid), 32'(m_nv));

    // Fill with 1..9; the ninth overflows
    for (int i = 1; i <= 9; i++) begin
      press(16'(1 << i), i, 10);
      sb_check("fill");
    end
    check("fill_word", digits, 32'h1234_5678);
    check("fill_count", 32'(digit_count), 32'd8);
    check("ovf_pulses", 32'(n_ovf), 32'(m_no));

    // Clear, then enter on an empty buffer
    press(16'h0800, 11, 10); sb_check("clear");
    press(16'h1000, 12, 10); sb_check("enter_empty");
    check("enter_empty_value", entry_value, 32'hFFFF_FFFF);
    check("enter_empty_pulses", 32'(n_valid), 32'(m_nv));

    // Backspace on empty buffer is a no-op
    press(16'h0400, 10, 10); sb_check("bksp_empty");

    // Bouncing key 5 then a clean hold appends a single 5
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      tick(2);
    end
    press(16'h0020, 5, 10); sb_check("bounce");

    // Chord does nothing; a following 7 appends
    press(16'h0006, -1, 10); sb_check("chord");
    press(16'h0080, 7, 10);  sb_check("after_chord");

    // Press with enable low, enable rises while held: no action
    enable = 1'b0;
    key    = 16'h0010;
    push_exp();
    tick(10);
    sb_check("en_low");
    enable = 1'b1;
    push_exp();
    tick(10);
    key = 16'h0;
    tick(10);
    sb_check("en_rise");
    press(16'h0010, 4, 10); sb_check("en_after");

    // Build count to 5 then reset while key 8 is held
    press(16'h0002, 1, 10); sb_check("pre_rst1");
    press(16'h0004, 2, 10); sb_check("pre_rst2");
    check("pre_rst_word", digits, 32'hFFF5_7412);
    key = 16'h0100;
    tick(3);
    check("pre_rst_count", 32'(digit_count), 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_digits", digits, 32'hFFFF_FFFF);
    check("arst_count", 32'(digit_count), 32'd0);
    check("arst_entry_value", entry_value, 32'h0);
    m_digits = 32'hFFFF_FFFF;
    m_count  = 4'd0;
    m_ev     = 32'h0;
    tick(2);
    #4;
    rst_n = 1'b1;
    lat = 0;
    while ((digit_count == 4'd0) && (lat < 20)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst_fire_latency_ok", 32'((lat >= int'(DEB) + 2) && (lat <= int'(DEB) + 4)), 32'd1);
    model_key(8);
    push_exp();
    tick(10);
    key = 16'h0;
    tick(10);
    sb_check("rst_fire");
    check("rst_fire_word", digits, 32'hFFFF_FFF8);

    // Pulse totals and widths across the run
    check("final_valid_pulses", 32'(n_valid), 32'(m_nv));
    check("final_ovf_pulses", 32'(n_ovf), 32'(m_no));
    check("pulse_width", 32'(dbl), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
